// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Target side of the byte-serial memory bus. It provides a
//               single-port byte RAM plus a memory-mapped I/O window with
//               UART TX/RX FIFOs and a status register. Read data returns
//               one cycle after the address is issued.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
   parameter int ADDR_WIDTH  = 17,
   parameter int TX_DEPTH    = 16,
   parameter int RX_DEPTH    = 16,
   parameter int FULL_MARGIN = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);

   localparam logic [17:0]    c_io_data  = 18'h30000;
   localparam logic [17:0]    c_io_stat  = 18'h30004;
   localparam logic [TX_AW:0] c_tx_depth = (TX_AW+1)'(TX_DEPTH);
   localparam logic [TX_AW:0] c_margin   = (TX_AW+1)'(FULL_MARGIN);
   localparam logic [RX_AW:0] c_rx_depth = (RX_AW+1)'(RX_DEPTH);

   // Storage arrays (no reset: contents are don't-care until written)
   logic [7:0] ram      [2**ADDR_WIDTH];
   logic [7:0] tx_mem_q [TX_DEPTH];
   logic [7:0] rx_mem_q [RX_DEPTH];

   // Registered state
   logic [7:0]       mem_din_q,        mem_din_d;
   logic             io_buffer_full_q, io_buffer_full_d;
   logic             tx_overflow_q,    tx_overflow_d;
   logic [TX_AW-1:0] tx_wr_ptr_q,      tx_wr_ptr_d;
   logic [TX_AW-1:0] tx_rd_ptr_q,      tx_rd_ptr_d;
   logic [TX_AW:0]   tx_count_q,       tx_count_d;
   logic [RX_AW-1:0] rx_wr_ptr_q,      rx_wr_ptr_d;
   logic [RX_AW-1:0] rx_rd_ptr_q,      rx_rd_ptr_d;
   logic [RX_AW:0]   rx_count_q,       rx_count_d;

   // Decode and handshake terms
   logic        io_sel;
   logic [17:0] io_off;
   logic        ram_wr;
   logic        tx_push_req;
   logic        tx_push;
   logic        tx_pop;
   logic        tx_full;
   logic        stat_wr;
   logic        rx_pop_req;
   logic        rx_pop;
   logic        rx_push;
   logic        rx_nonempty;
   logic        rx_full;
   logic [TX_AW:0] tx_free_next;
   logic [7:0]  status;
   logic        unused_addr_bits;

   // Upper address bits are outside the decoded window
   assign unused_addr_bits = ^mem_a[31:18];

   // Address decode, FIFO flags and accepted push/pop strobes
   always_comb begin
      io_off      = mem_a[17:0];
      io_sel      = (mem_a[17:16] == 2'b11);
      ram_wr      = rdy_in & mem_wr & ~io_sel;
      tx_full     = (tx_count_q == c_tx_depth);
      rx_full     = (rx_count_q == c_rx_depth);
      rx_nonempty = (rx_count_q != '0);
      tx_push_req = rdy_in & io_sel & mem_wr & (io_off == c_io_data);
      stat_wr     = rdy_in & io_sel & mem_wr & (io_off == c_io_stat);
      rx_pop_req  = rdy_in & io_sel & ~mem_wr & (io_off == c_io_data);
      tx_pop      = rdy_in & tx_valid & tx_ready;
      // A pop in the same cycle frees a slot, so a push into a full FIFO is kept
      tx_push     = tx_push_req & (~tx_full | tx_pop);
      rx_push     = rdy_in & rx_valid & ~rx_full;
      rx_pop      = rx_pop_req & rx_nonempty;
      status      = {5'b0, tx_overflow_q, tx_full, rx_nonempty};
   end

   // Next-state for TX/RX pointers, counts, overflow flag and bus outputs
   always_comb begin
      tx_wr_ptr_d      = tx_wr_ptr_q;
      tx_rd_ptr_d      = tx_rd_ptr_q;
      tx_count_d       = tx_count_q;
      rx_wr_ptr_d      = rx_wr_ptr_q;
      rx_rd_ptr_d      = rx_rd_ptr_q;
      rx_count_d       = rx_count_q;
      tx_overflow_d    = tx_overflow_q;
      mem_din_d        = mem_din_q;
      io_buffer_full_d = io_buffer_full_q;
      tx_free_next     = '0;

      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(1);
      if (tx_push && !tx_pop) tx_count_d = tx_count_q + (TX_AW+1)'(1);
      if (!tx_push && tx_pop) tx_count_d = tx_count_q - (TX_AW+1)'(1);

      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(1);
      if (rx_push && !rx_pop) rx_count_d = rx_count_q + (RX_AW+1)'(1);
      if (!rx_push && rx_pop) rx_count_d = rx_count_q - (RX_AW+1)'(1);

      if (stat_wr)
         tx_overflow_d = 1'b0;
      else if (tx_push_req && !tx_push)
         tx_overflow_d = 1'b1;

      if (rdy_in) begin
         tx_free_next     = c_tx_depth - tx_count_d;
         io_buffer_full_d = (tx_free_next <= c_margin);
      end

      // Writes leave the read-data register untouched
      if (rdy_in && !mem_wr) begin
         if (!io_sel)
            mem_din_d = ram[mem_a[ADDR_WIDTH-1:0]];
         else if (io_off == c_io_data)
            mem_din_d = rx_nonempty ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
         else if (io_off == c_io_stat)
            mem_din_d = status;
         else
            mem_din_d = 8'h00;
      end
   end

   // Control/state registers with asynchronous active-low reset
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mem_din_q        <= 8'h00;
         io_buffer_full_q <= 1'b0;
         tx_overflow_q    <= 1'b0;
         tx_wr_ptr_q      <= '0;
         tx_rd_ptr_q      <= '0;
         tx_count_q       <= '0;
         rx_wr_ptr_q      <= '0;
         rx_rd_ptr_q      <= '0;
         rx_count_q       <= '0;
      end else begin
         mem_din_q        <= mem_din_d;
         io_buffer_full_q <= io_buffer_full_d;
         tx_overflow_q    <= tx_overflow_d;
         tx_wr_ptr_q      <= tx_wr_ptr_d;
         tx_rd_ptr_q      <= tx_rd_ptr_d;
         tx_count_q       <= tx_count_d;
         rx_wr_ptr_q      <= rx_wr_ptr_d;
         rx_rd_ptr_q      <= rx_rd_ptr_d;
         rx_count_q       <= rx_count_d;
      end
   end

   // Data storage writes; RAM and FIFO bodies are never reset
   always_ff @(posedge clk_in) begin
      if (ram_wr)  ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
      if (tx_push) tx_mem_q[tx_wr_ptr_q]      <= mem_dout;
      if (rx_push) rx_mem_q[rx_wr_ptr_q]      <= rx_data;
   end

   assign mem_din        = mem_din_q;
   assign io_buffer_full = io_buffer_full_q;
   assign tx_valid       = (tx_count_q != '0);
   assign tx_data        = tx_mem_q[tx_rd_ptr_q];
   assign rx_ready       = ~rx_full;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_responder
// Description : Directed self-checking bench for mem_io_responder: RAM
//               access, TX/RX FIFOs, status register, freeze and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   int n_total = 0;
   int n_bad   = 0;

   mem_io_responder dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready)
   );

   // 100 MHz-style clock
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus transfer; returns 1 time unit after the capturing edge
   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
      @(posedge clk_in);
      #1;
   endtask

   // Harmless transfer: read of an unmapped IO address (returns 0)
   task automatic idle();
      bus(32'h0003_0008, 1'b0, 8'h00);
   endtask

   logic [7:0] exp_tx [16];

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
      tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_mem_din", mem_din, 8'h00);
      check("rst_iobf", io_buffer_full, 1'b0);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_rx_ready", rx_ready, 1'b1);
      rst_in = 1'b1;

      // ---------------- RAM write / read ----------------
      bus(32'h100, 1'b1, 8'h11);
      bus(32'h101, 1'b1, 8'h22);
      bus(32'h102, 1'b1, 8'h33);
      bus(32'h103, 1'b1, 8'h44);
      bus(32'h100, 1'b0, 8'h00); check("ram_rd_100", mem_din, 8'h11);
      bus(32'h101, 1'b0, 8'h00); check("ram_rd_101", mem_din, 8'h22);
      bus(32'h102, 1'b0, 8'h00); check("ram_rd_102", mem_din, 8'h33);
      bus(32'h103, 1'b0, 8'h00); check("ram_rd_103", mem_din, 8'h44);
      bus(32'h200, 1'b1, 8'h77);
      bus(32'h200, 1'b0, 8'h00); check("ram_raw", mem_din, 8'h77);
      // Upper RAM half and a write leaves mem_din alone
      bus(32'h1FFFF, 1'b1, 8'hC3); check("wr_hold_din", mem_din, 8'h77);
      bus(32'h1FFFF, 1'b0, 8'h00); check("ram_rd_top", mem_din, 8'hC3);

      // ---------------- RX FIFO ----------------
      rx_valid = 1'b1; rx_data = 8'h5A;
      idle();
      rx_data = 8'hA5;
      idle();
      rx_valid = 1'b0;
      check("rx_idle_din", mem_din, 8'h00);
      bus(32'h30004, 1'b0, 8'h00); check("rx_stat_1", mem_din, 8'h01);
      bus(32'h30000, 1'b0, 8'h00); check("rx_pop_5a", mem_din, 8'h5A);
      bus(32'h30000, 1'b0, 8'h00); check("rx_pop_a5", mem_din, 8'hA5);
      bus(32'h30000, 1'b0, 8'h00); check("rx_pop_empty", mem_din, 8'h00);
      bus(32'h30004, 1'b0, 8'h00); check("rx_stat_0", mem_din, 8'h00);

      // ---------------- TX fill / overflow ----------------
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus(32'h30000, 1'b1, 8'(8'h80 + i));
         check($sformatf("tx_iobf_%0d", i + 1), io_buffer_full, (i + 1 >= 12) ? 1 : 0);
      end
      check("tx_valid_full", tx_valid, 1'b1);
      check("tx_head_80", tx_data, 8'h80);
      bus(32'h30004, 1'b0, 8'h00); check("tx_stat_full", mem_din, 8'h02);
      bus(32'h30000, 1'b1, 8'h90);
      bus(32'h30004, 1'b0, 8'h00); check("tx_stat_ovf", mem_din, 8'h06);
      bus(32'h30004, 1'b1, 8'h00);
      bus(32'h30004, 1'b0, 8'h00); check("tx_stat_clr", mem_din, 8'h02);

      // ---------------- TX push+pop while full ----------------
      tx_ready = 1'b1;
      bus(32'h30000, 1'b1, 8'h91);
      tx_ready = 1'b0;
      check("tx_pp_head", tx_data, 8'h81);
      check("tx_pp_iobf", io_buffer_full, 1'b1);
      bus(32'h30004, 1'b0, 8'h00); check("tx_pp_stat", mem_din, 8'h02);

      // Drain: expected order 0x81..0x8F then 0x91
      for (int i = 0; i < 15; i++) exp_tx[i] = 8'(8'h81 + i);
      exp_tx[15] = 8'h91;
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("tx_drain_%0d", i), {tx_valid, tx_data}, {1'b1, exp_tx[i]});
         idle();
      end
      tx_ready = 1'b0;
      check("tx_empty", tx_valid, 1'b0);
      check("tx_empty_iobf", io_buffer_full, 1'b0);

      // ---------------- rdy_in freeze ----------------
      bus(32'h300, 1'b1, 8'hAA);
      bus(32'h30000, 1'b1, 8'h42);
      bus(32'h300, 1'b0, 8'h00); check("frz_pre_din", mem_din, 8'hAA);
      rdy_in = 1'b0; mem_a = 32'h300; mem_wr = 1'b1; mem_dout = 8'h55;
      tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_in);
         #1;
         check($sformatf("frz_din_%0d", i), mem_din, 8'hAA);
         check($sformatf("frz_tx_%0d", i), {tx_valid, tx_data}, {1'b1, 8'h42});
      end
      rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
      bus(32'h300, 1'b0, 8'h00);   check("frz_ram", mem_din, 8'hAA);
      bus(32'h30004, 1'b0, 8'h00); check("frz_stat", mem_din, 8'h00);
      check("frz_tx_head", tx_data, 8'h42);

      // ---------------- reset mid-read ----------------
      for (int i = 0; i < 11; i++) bus(32'h30000, 1'b1, 8'(i));
      check("pre_rst_iobf", io_buffer_full, 1'b1);
      rx_valid = 1'b1; rx_data = 8'h33;
      bus(32'h400, 1'b1, 8'h99);
      rx_valid = 1'b0;
      mem_a = 32'h30000; mem_wr = 1'b0;
      #3;
      rst_in = 1'b0;
      #1;
      check("mid_rst_din", mem_din, 8'h00);
      check("mid_rst_tx_valid", tx_valid, 1'b0);
      check("mid_rst_iobf", io_buffer_full, 1'b0);
      check("mid_rst_rx_ready", rx_ready, 1'b1);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      check("post_rst_din", mem_din, 8'h00);
      bus(32'h400, 1'b0, 8'h00);   check("post_rst_ram", mem_din, 8'h99);
      bus(32'h30004, 1'b0, 8'h00); check("post_rst_stat", mem_din, 8'h00);
      bus(32'h30000, 1'b0, 8'h00); check("post_rst_rx", mem_din, 8'h00);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
